// File: rtl/turn_sequencer_pkg.sv
// Shared definitions for the turn sequencer: FSM state encoding, move codes,
// datapath widths and the accuracy roll rule.
package pbs_pkg;

  localparam int HP_W       = 4;
  localparam int TURN_CNT_W = 8;

  // An accuracy of all-ones always hits, whatever the random value.
  localparam logic [3:0] ACCU_ALWAYS = 4'hF;

  typedef enum logic [1:0] {
    MV_0 = 2'd0,
    MV_1 = 2'd1,
    MV_2 = 2'd2,
    MV_3 = 2'd3
  } move_e;

  typedef enum logic [3:0] {
    S_INIT,
    S_IDLE,
    S_P_ROLL,
    S_P_APPLY,
    S_P_CHK,
    S_AI_ROLL,
    S_AI_APPLY,
    S_AI_CHK,
    S_DONE,
    S_WIN,
    S_LOSS
  } state_e;

  // Unsigned compare; rng equal to accu is a miss.
  function automatic logic roll_hit(input logic [3:0] accu, input logic [3:0] rng);
    return (accu == ACCU_ALWAYS) || (rng < accu);
  endfunction

endpackage

// File: rtl/turn_sequencer_if.sv
// Sequencer <-> datapath bundle.
//   move_sel   : move presented to the datapath move mux
//   actr       : active trainer (0 player, 1 AI)
//   target     : damage target (1 AI)
//   accu, dmg  : stats of the move on move_sel, combinational from the datapath
//   rng        : accuracy random value
//   p_hp, ai_hp: current hit points
//   load_ai_hp, app_pl_dmg, app_ai_dmg : single-cycle datapath strobes
interface turn_sequencer_if;
  import pbs_pkg::*;

  logic [1:0]      move_sel;
  logic            actr;
  logic            target;
  logic [3:0]      accu;
  logic [3:0]      dmg;
  logic [3:0]      rng;
  logic [HP_W-1:0] p_hp;
  logic [HP_W-1:0] ai_hp;
  logic            load_ai_hp;
  logic            app_pl_dmg;
  logic            app_ai_dmg;

  modport master (
    output move_sel, actr, target, load_ai_hp, app_pl_dmg, app_ai_dmg,
    input  accu, dmg, rng, p_hp, ai_hp
  );

  modport slave (
    input  move_sel, actr, target, load_ai_hp, app_pl_dmg, app_ai_dmg,
    output accu, dmg, rng, p_hp, ai_hp
  );

endinterface

// File: rtl/turn_sequencer_lfsr4.sv
// Free-running 4-bit Fibonacci LFSR, x^4 + x^3 + 1, period 15.
//   clk : system clock
//   rst : synchronous active-high reset, reloads seed 4'b0001
//   q   : current LFSR value
module lfsr4 (
  input  logic       clk,
  input  logic       rst,
  output logic [3:0] q
);

  logic [3:0] q_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      q_q <= 4'b0001;
    end else begin
      q_q <= {q_q[2:0], q_q[3] ^ q_q[2]};
    end
  end

  assign q = q_q;

endmodule

// File: rtl/turn_sequencer.sv
// Battle turn sequencer: on a rising edge of go, runs one player roll/apply/
// check followed by one AI roll/apply/check, steering the datapath through dp.
//   clk, rst   : system clock, synchronous active-high reset
//   go         : turn request level; a turn starts on its rising edge in IDLE
//   p_move     : player move code, latched at turn start
//   dp         : datapath bundle (master side)
//   busy, done : turn in progress / one-cycle end-of-turn pulse
//   hit        : result of the most recent roll
//   victory, loss : terminal outcome flags, cleared only by rst
//   turn_cnt   : completed turns, saturating
//
// state      | meaning
// INIT       | pulse load_ai_hp once after reset
// IDLE       | wait for go rising edge
// P_ROLL     | player move on datapath, roll accuracy
// P_APPLY    | apply player damage to AI on hit
// P_CHK      | AI defeated? else pick AI move from LFSR
// AI_ROLL    | AI move on datapath, roll accuracy
// AI_APPLY   | apply AI damage to player on hit
// AI_CHK     | player defeated?
// DONE       | end-of-turn pulse, bump turn counter
// WIN / LOSS | terminal until rst
module turn_sequencer
  import pbs_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  go,
  input  logic [1:0]            p_move,
  turn_sequencer_if.master      dp,
  output logic                  busy,
  output logic                  done,
  output logic                  hit,
  output logic                  victory,
  output logic                  loss,
  output logic [TURN_CNT_W-1:0] turn_cnt
);

  state_e                state_q, state_d;
  move_e                 mv_q, mv_d;
  move_e                 ai_mv_q, ai_mv_d;
  logic                  hit_q, hit_d;
  logic                  go_q;
  logic [TURN_CNT_W-1:0] turn_cnt_q, turn_cnt_d;
  logic [3:0]            lfsr_q;

  logic [1:0] move_sel;
  logic       actr, target, load_ai_hp, app_pl_dmg, app_ai_dmg;

  // dmg belongs to the datapath only; upper LFSR bits are not needed here.
  logic unused_ok;
  assign unused_ok = ^{dp.dmg, lfsr_q[3:2]};

  lfsr4 u_lfsr (
    .clk (clk),
    .rst (rst),
    .q   (lfsr_q)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_INIT;
      mv_q       <= MV_0;
      ai_mv_q    <= MV_0;
      hit_q      <= 1'b0;
      go_q       <= 1'b0;
      turn_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      mv_q       <= mv_d;
      ai_mv_q    <= ai_mv_d;
      hit_q      <= hit_d;
      go_q       <= go;
      turn_cnt_q <= turn_cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    mv_d       = mv_q;
    ai_mv_d    = ai_mv_q;
    hit_d      = hit_q;
    turn_cnt_d = turn_cnt_q;
    move_sel   = mv_q;
    actr       = 1'b0;
    target     = 1'b0;
    load_ai_hp = 1'b0;
    app_pl_dmg = 1'b0;
    app_ai_dmg = 1'b0;
    busy       = 1'b1;
    done       = 1'b0;
    victory    = 1'b0;
    loss       = 1'b0;

    case (state_q)
      S_INIT: begin
        load_ai_hp = 1'b1;
        state_d    = S_IDLE;
      end
      S_IDLE: begin
        busy = 1'b0;
        if (go && !go_q) begin
          mv_d    = move_e'(p_move);
          state_d = S_P_ROLL;
        end
      end
      S_P_ROLL: begin
        hit_d   = roll_hit(dp.accu, dp.rng);
        state_d = S_P_APPLY;
      end
      S_P_APPLY: begin
        target     = 1'b1;
        app_ai_dmg = hit_q;
        state_d    = S_P_CHK;
      end
      S_P_CHK: begin
        if (dp.ai_hp == '0) begin
          state_d = S_WIN;
        end else begin
          ai_mv_d = move_e'(lfsr_q[1:0]);
          state_d = S_AI_ROLL;
        end
      end
      S_AI_ROLL: begin
        move_sel = ai_mv_q;
        actr     = 1'b1;
        hit_d    = roll_hit(dp.accu, dp.rng);
        state_d  = S_AI_APPLY;
      end
      S_AI_APPLY: begin
        move_sel   = ai_mv_q;
        app_pl_dmg = hit_q;
        state_d    = S_AI_CHK;
      end
      S_AI_CHK: begin
        state_d = (dp.p_hp == '0) ? S_LOSS : S_DONE;
      end
      S_DONE: begin
        done = 1'b1;
        if (turn_cnt_q != '1) begin
          turn_cnt_d = turn_cnt_q + 1'b1;
        end
        state_d = S_IDLE;
      end
      S_WIN: begin
        busy    = 1'b0;
        victory = 1'b1;
      end
      S_LOSS: begin
        busy = 1'b0;
        loss = 1'b1;
      end
      default: state_d = S_INIT;
    endcase

    // The state is only replaced at the next edge, so strobes must be
    // masked combinationally to stay quiet in the cycle rst is applied.
    if (rst) begin
      load_ai_hp = 1'b0;
      app_pl_dmg = 1'b0;
      app_ai_dmg = 1'b0;
    end
  end

  assign dp.move_sel   = move_sel;
  assign dp.actr       = actr;
  assign dp.target     = target;
  assign dp.load_ai_hp = load_ai_hp;
  assign dp.app_pl_dmg = app_pl_dmg;
  assign dp.app_ai_dmg = app_ai_dmg;
  assign hit           = hit_q;
  assign turn_cnt      = turn_cnt_q;

endmodule

// File: tb/tb_turn_sequencer.sv
// Directed bench for turn_sequencer. Inputs change 1 time unit after the
// rising edge; outputs are observed at that same point.
module tb_turn_sequencer;
  import pbs_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       go;
  logic [1:0] p_move;
  logic       busy, done, hit, victory, loss;
  logic [7:0] turn_cnt;

  int checks = 0;
  int errors = 0;

  turn_sequencer_if dp ();

  turn_sequencer dut (
    .clk      (clk),
    .rst      (rst),
    .go       (go),
    .p_move   (p_move),
    .dp       (dp),
    .busy     (busy),
    .done     (done),
    .hit      (hit),
    .victory  (victory),
    .loss     (loss),
    .turn_cnt (turn_cnt)
  );

  always #5 clk = ~clk;

  // Reference LFSR sequence from seed 1 for x^4+x^3+1, written out by hand.
  function automatic logic [3:0] ref_seq(input int i);
    case (i)
      0: return 4'h1;   1: return 4'h2;   2: return 4'h4;   3: return 4'h9;
      4: return 4'h3;   5: return 4'h6;   6: return 4'hD;   7: return 4'hA;
      8: return 4'h5;   9: return 4'hB;  10: return 4'h7;  11: return 4'hF;
     12: return 4'hE;  13: return 4'hC;  default: return 4'h8;
    endcase
  endfunction

  int         ref_idx;
  logic [3:0] ref_prev;   // LFSR value during the previous cycle

  always @(posedge clk) begin
    if (rst) begin
      ref_idx  <= 0;
      ref_prev <= 4'h1;
    end else begin
      ref_prev <= ref_seq(ref_idx);
      ref_idx  <= (ref_idx == 14) ? 0 : ref_idx + 1;
    end
  end

  task automatic cyc;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst = 1'b1;
    go  = 1'b0;
    cyc();
    cyc();
    rst = 1'b0;
    cyc();
  endtask

  // Runs one go edge and records 8 cycles; bit k is cycle N+k+1.
  task automatic do_turn(input logic [1:0] mv,
                         output logic [7:0] ai, output logic [7:0] pl,
                         output logic [7:0] dn, output logic [7:0] bz,
                         output logic [7:0] ac, output logic [7:0] tg,
                         output logic [7:0] vi, output logic [7:0] lo,
                         output logic [1:0] ms_p, output logic [1:0] ms_ai,
                         output logic [1:0] exp_ai);
    ai = '0; pl = '0; dn = '0; bz = '0; ac = '0; tg = '0; vi = '0; lo = '0;
    ms_p = '0; ms_ai = '0; exp_ai = '0;
    go = 1'b0;
    cyc();
    p_move = mv;
    go     = 1'b1;
    for (int k = 0; k < 8; k++) begin
      cyc();
      ai[k] = dp.app_ai_dmg;
      pl[k] = dp.app_pl_dmg;
      dn[k] = done;
      bz[k] = busy;
      ac[k] = dp.actr;
      tg[k] = dp.target;
      vi[k] = victory;
      lo[k] = loss;
      if (k == 0) p_move = ~mv;
      if (k == 1) ms_p = dp.move_sel;
      if (k == 3) begin
        ms_ai  = dp.move_sel;
        exp_ai = ref_prev[1:0];
      end
    end
  endtask

  logic [7:0] r_ai, r_pl, r_dn, r_bz, r_ac, r_tg, r_vi, r_lo;
  logic [1:0] r_msp, r_msai, r_expai;

  task automatic test_reset;
    rst = 1'b1; go = 1'b0; p_move = 2'd0;
    dp.accu = 4'hF; dp.rng = 4'h0; dp.dmg = 4'h1; dp.p_hp = 4'd5; dp.ai_hp = 4'd5;
    cyc();
    cyc();
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rst_busy got %b want 1", busy); end
    checks++; if (dp.load_ai_hp !== 1'b0) begin errors++; $display("FAIL rst_load_masked got %b want 0", dp.load_ai_hp); end
    checks++; if ({done, hit, victory, loss, dp.actr, dp.target, dp.app_pl_dmg, dp.app_ai_dmg} !== 8'h00)
      begin errors++; $display("FAIL rst_outputs got %b want 00000000",
        {done, hit, victory, loss, dp.actr, dp.target, dp.app_pl_dmg, dp.app_ai_dmg}); end
    checks++; if (turn_cnt !== 8'h00) begin errors++; $display("FAIL rst_turn_cnt got %h want 00", turn_cnt); end
    checks++; if (dp.move_sel !== 2'd0) begin errors++; $display("FAIL rst_move_sel got %0d want 0", dp.move_sel); end
    rst = 1'b0;
    #1;
    checks++; if (dp.load_ai_hp !== 1'b1) begin errors++; $display("FAIL init_load got %b want 1", dp.load_ai_hp); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL init_busy got %b want 1", busy); end
    cyc();
    checks++; if (dp.load_ai_hp !== 1'b0) begin errors++; $display("FAIL init_load_once got %b want 0", dp.load_ai_hp); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL idle_busy got %b want 0", busy); end
    cyc();
    checks++; if (dp.load_ai_hp !== 1'b0 || busy !== 1'b0) begin errors++;
      $display("FAIL idle_stable got load=%b busy=%b want 0 0", dp.load_ai_hp, busy); end
  endtask

  task automatic test_full_turn;
    dp.accu = 4'hF; dp.rng = 4'hF; dp.p_hp = 4'd5; dp.ai_hp = 4'd5;
    do_turn(2'd2, r_ai, r_pl, r_dn, r_bz, r_ac, r_tg, r_vi, r_lo, r_msp, r_msai, r_expai);
    checks++; if (r_ai !== 8'h02) begin errors++; $display("FAIL full_app_ai got %b want 00000010", r_ai); end
    checks++; if (r_pl !== 8'h10) begin errors++; $display("FAIL full_app_pl got %b want 00010000", r_pl); end
    checks++; if (r_dn !== 8'h40) begin errors++; $display("FAIL full_done got %b want 01000000", r_dn); end
    checks++; if (r_bz !== 8'h7F) begin errors++; $display("FAIL full_busy got %b want 01111111", r_bz); end
    checks++; if (r_ac !== 8'h08) begin errors++; $display("FAIL full_actr got %b want 00001000", r_ac); end
    checks++; if (r_tg !== 8'h02) begin errors++; $display("FAIL full_target got %b want 00000010", r_tg); end
    checks++; if ((r_vi | r_lo) !== 8'h00) begin errors++; $display("FAIL full_outcome got %b want 00000000", r_vi | r_lo); end
    checks++; if (r_msp !== 2'd2) begin errors++; $display("FAIL full_move_latch got %0d want 2", r_msp); end
    checks++; if (r_msai !== r_expai) begin errors++; $display("FAIL full_ai_move got %0d want %0d", r_msai, r_expai); end
    checks++; if (turn_cnt !== 8'd1) begin errors++; $display("FAIL full_turn_cnt got %0d want 1", turn_cnt); end
    checks++; if (hit !== 1'b1) begin errors++; $display("FAIL full_hit got %b want 1", hit); end
  endtask

  task automatic test_miss_hit;
    dp.accu = 4'h3; dp.rng = 4'h9;
    do_turn(2'd1, r_ai, r_pl, r_dn, r_bz, r_ac, r_tg, r_vi, r_lo, r_msp, r_msai, r_expai);
    checks++; if ((r_ai | r_pl) !== 8'h00) begin errors++; $display("FAIL miss_strobes got %b want 00000000", r_ai | r_pl); end
    checks++; if (hit !== 1'b0) begin errors++; $display("FAIL miss_hit got %b want 0", hit); end
    checks++; if (r_dn !== 8'h40) begin errors++; $display("FAIL miss_done got %b want 01000000", r_dn); end
    dp.rng = 4'h2;
    do_turn(2'd3, r_ai, r_pl, r_dn, r_bz, r_ac, r_tg, r_vi, r_lo, r_msp, r_msai, r_expai);
    checks++; if (r_ai !== 8'h02) begin errors++; $display("FAIL hit_app_ai got %b want 00000010", r_ai); end
    checks++; if (r_pl !== 8'h10) begin errors++; $display("FAIL hit_app_pl got %b want 00010000", r_pl); end
    checks++; if (hit !== 1'b1) begin errors++; $display("FAIL hit_hit got %b want 1", hit); end
    dp.accu = 4'h5; dp.rng = 4'h5;
    do_turn(2'd0, r_ai, r_pl, r_dn, r_bz, r_ac, r_tg, r_vi, r_lo, r_msp, r_msai, r_expai);
    checks++; if ((r_ai | r_pl) !== 8'h00) begin errors++; $display("FAIL equal_miss got %b want 00000000", r_ai | r_pl); end
    checks++; if (turn_cnt !== 8'd4) begin errors++; $display("FAIL miss_turn_cnt got %0d want 4", turn_cnt); end
  endtask

  task automatic test_win;
    do_reset();
    dp.accu = 4'hF; dp.rng = 4'h0; dp.p_hp = 4'd5; dp.ai_hp = 4'd0;
    do_turn(2'd3, r_ai, r_pl, r_dn, r_bz, r_ac, r_tg, r_vi, r_lo, r_msp, r_msai, r_expai);
    checks++; if (r_vi !== 8'hF8) begin errors++; $display("FAIL win_victory got %b want 11111000", r_vi); end
    checks++; if (r_bz !== 8'h07) begin errors++; $display("FAIL win_busy got %b want 00000111", r_bz); end
    checks++; if ((r_pl | r_dn | r_ac) !== 8'h00) begin errors++; $display("FAIL win_no_ai got %b want 00000000", r_pl | r_dn | r_ac); end
    go = 1'b0; cyc(); go = 1'b1; cyc(); cyc(); cyc();
    checks++; if (victory !== 1'b1 || busy !== 1'b0) begin errors++;
      $display("FAIL win_terminal got victory=%b busy=%b want 1 0", victory, busy); end
    checks++; if (turn_cnt !== 8'd0) begin errors++; $display("FAIL win_turn_cnt got %0d want 0", turn_cnt); end
    go = 1'b0;
  endtask

  task automatic test_loss;
    do_reset();
    dp.accu = 4'hF; dp.p_hp = 4'd0; dp.ai_hp = 4'd5;
    do_turn(2'd0, r_ai, r_pl, r_dn, r_bz, r_ac, r_tg, r_vi, r_lo, r_msp, r_msai, r_expai);
    checks++; if (r_lo !== 8'hC0) begin errors++; $display("FAIL loss_flag got %b want 11000000", r_lo); end
    checks++; if (r_bz !== 8'h3F) begin errors++; $display("FAIL loss_busy got %b want 00111111", r_bz); end
    checks++; if (r_pl !== 8'h10 || r_dn !== 8'h00) begin errors++;
      $display("FAIL loss_pl_done got pl=%b done=%b want 00010000 00000000", r_pl, r_dn); end
    go = 1'b0; cyc(); go = 1'b1; cyc(); cyc();
    checks++; if (loss !== 1'b1 || busy !== 1'b0) begin errors++;
      $display("FAIL loss_terminal got loss=%b busy=%b want 1 0", loss, busy); end
    go = 1'b0;
  endtask

  task automatic test_go_held;
    int nd;
    do_reset();
    dp.p_hp = 4'd5; dp.ai_hp = 4'd5;
    nd = 0;
    go = 1'b1;
    for (int i = 0; i < 20; i++) begin
      cyc();
      if (done === 1'b1) nd++;
    end
    checks++; if (nd != 1) begin errors++; $display("FAIL held_done_count got %0d want 1", nd); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL held_idle_busy got %b want 0", busy); end
    go = 1'b0;
  endtask

  task automatic test_back_to_back;
    int nd;
    go = 1'b0;
    cyc();
    go = 1'b1;
    nd = 0;
    for (int i = 0; i < 20; i++) begin
      cyc();
      if (i == 1) go = 1'b0;
      if (i == 2) go = 1'b1;
      if (done === 1'b1) nd++;
    end
    checks++; if (nd != 1) begin errors++; $display("FAIL busy_edge_done_count got %0d want 1", nd); end
    checks++; if (busy !== 1'b0 || turn_cnt !== 8'd2) begin errors++;
      $display("FAIL busy_edge_idle got busy=%b cnt=%0d want 0 2", busy, turn_cnt); end
    go = 1'b0;
  endtask

  task automatic test_rst_mid;
    do_reset();
    dp.accu = 4'hF; dp.p_hp = 4'd5; dp.ai_hp = 4'd5;
    go = 1'b1;
    cyc();
    cyc();
    rst = 1'b1;
    #1;
    checks++; if (dp.app_ai_dmg !== 1'b0) begin errors++; $display("FAIL rst_masks_app_ai got %b want 0", dp.app_ai_dmg); end
    cyc();
    rst = 1'b0;
    go  = 1'b0;
    cyc();
    go = 1'b1;
    cyc(); cyc(); cyc(); cyc();
    checks++; if (dp.actr !== 1'b1) begin errors++; $display("FAIL rst_reach_ai_roll got actr=%b want 1", dp.actr); end
    rst = 1'b1;
    #1;
    checks++; if ({dp.load_ai_hp, dp.app_pl_dmg, dp.app_ai_dmg} !== 3'b000) begin errors++;
      $display("FAIL rst_ai_strobes got %b want 000", {dp.load_ai_hp, dp.app_pl_dmg, dp.app_ai_dmg}); end
    cyc();
    checks++; if (busy !== 1'b1 || dp.actr !== 1'b0 || dp.move_sel !== 2'd0) begin errors++;
      $display("FAIL rst_init got busy=%b actr=%b ms=%0d want 1 0 0", busy, dp.actr, dp.move_sel); end
    checks++; if ({dp.load_ai_hp, dp.app_pl_dmg, dp.app_ai_dmg} !== 3'b000) begin errors++;
      $display("FAIL rst_init_strobes got %b want 000", {dp.load_ai_hp, dp.app_pl_dmg, dp.app_ai_dmg}); end
    rst = 1'b0;
    #1;
    checks++; if (dp.load_ai_hp !== 1'b1) begin errors++; $display("FAIL rst_reload got %b want 1", dp.load_ai_hp); end
    cyc();
    checks++; if (busy !== 1'b0 || dp.load_ai_hp !== 1'b0) begin errors++;
      $display("FAIL rst_back_idle got busy=%b load=%b want 0 0", busy, dp.load_ai_hp); end
    go = 1'b0;
  endtask

  task automatic test_saturation;
    do_reset();
    dp.accu = 4'hF; dp.rng = 4'h0; dp.p_hp = 4'd5; dp.ai_hp = 4'd5;
    for (int t = 0; t < 256; t++) begin
      do_turn(t[1:0], r_ai, r_pl, r_dn, r_bz, r_ac, r_tg, r_vi, r_lo, r_msp, r_msai, r_expai);
      checks++; if (r_msai !== r_expai) begin errors++;
        $display("FAIL sat_ai_move turn %0d got %0d want %0d", t, r_msai, r_expai); end
      if (t == 0) begin
        checks++; if (turn_cnt !== 8'd1) begin errors++; $display("FAIL sat_first got %0d want 1", turn_cnt); end
      end
      if (t == 254) begin
        checks++; if (turn_cnt !== 8'hFF) begin errors++; $display("FAIL sat_reach got %h want ff", turn_cnt); end
      end
    end
    checks++; if (turn_cnt !== 8'hFF) begin errors++; $display("FAIL sat_hold got %h want ff", turn_cnt); end
    checks++; if (r_dn !== 8'h40) begin errors++; $display("FAIL sat_done got %b want 01000000", r_dn); end
  endtask

  initial begin
    test_reset();
    test_full_turn();
    test_miss_hit();
    test_win();
    test_loss();
    test_go_held();
    test_back_to_back();
    test_rst_mid();
    test_saturation();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
